// File: rtl/core_memory_responder_pkg.sv
// Shared types and defaults for the core memory responder.
package core_memory_responder_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 32;
  localparam int unsigned DEFAULT_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/core_memory_responder_rr_arbiter.sv
// Round-robin pick: first eligible core strictly after ptr, wrapping.
module core_memory_responder_rr_arbiter #(
  parameter int unsigned NUM_CORES = 2,
  parameter int unsigned IDX_W     = 1
) (
  input  logic [NUM_CORES-1:0] eligible,
  input  logic [IDX_W-1:0]     ptr,
  output logic                 any_c,
  output logic [NUM_CORES-1:0] grant_oh_c,
  output logic [IDX_W-1:0]     grant_idx_c
);

  // Scan from ptr+1 around to ptr itself; the first hit wins.
  always_comb begin
    int unsigned cand;
    any_c       = 1'b0;
    grant_oh_c  = '0;
    grant_idx_c = '0;
    cand        = 0;
    for (int unsigned k = 1; k <= NUM_CORES; k++) begin
      cand = (32'(ptr) + k) % NUM_CORES;
      if (!any_c && eligible[IDX_W'(cand)]) begin
        any_c                    = 1'b1;
        grant_oh_c[IDX_W'(cand)] = 1'b1;
        grant_idx_c              = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/core_memory_responder.sv
// Serves NUM_CORES cores round-robin against one fixed-latency single-port memory.
module core_memory_responder
  import core_memory_responder_pkg::*;
#(
  parameter int unsigned NUM_CORES   = 2,
  parameter int unsigned ADDR_W      = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W      = DEFAULT_DATA_W,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        core_request,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES-1:0]        core_rden,
  input  logic [NUM_CORES-1:0]        core_wren,
  input  logic [NUM_CORES*DATA_W-1:0] core_write_val,
  output logic [NUM_CORES-1:0]        core_enable,
  output logic [DATA_W-1:0]           core_read_val,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_rden,
  output logic                        mem_wren,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int unsigned IDX_W = idx_width(NUM_CORES);
  localparam int unsigned CNT_W = idx_width(MEM_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(NUM_CORES - 1);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       gnt_idx_q, gnt_idx_d;
  logic [NUM_CORES-1:0]   gnt_oh_q, gnt_oh_d;
  logic                   is_wr_q, is_wr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [NUM_CORES-1:0]   core_enable_q, core_enable_d;
  logic [DATA_W-1:0]      core_read_val_q, core_read_val_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic                   mem_rden_q, mem_rden_d;
  logic                   mem_wren_q, mem_wren_d;
  logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;

  logic [NUM_CORES-1:0]   eligible_c;
  logic                   any_c;
  logic [NUM_CORES-1:0]   arb_oh_c;
  logic [IDX_W-1:0]       arb_idx_c;
  logic [ADDR_W-1:0]      sel_addr_c;
  logic [DATA_W-1:0]      sel_wdata_c;
  logic                   sel_wr_c;

  // A request only counts when it carries a read or write qualifier.
  assign eligible_c = core_request & (core_rden | core_wren);

  core_memory_responder_rr_arbiter #(
    .NUM_CORES (NUM_CORES),
    .IDX_W     (IDX_W)
  ) u_arb (
    .eligible    (eligible_c),
    .ptr         (ptr_q),
    .any_c       (any_c),
    .grant_oh_c  (arb_oh_c),
    .grant_idx_c (arb_idx_c)
  );

  // Winner's payload; write takes precedence when both qualifiers are set.
  always_comb begin
    sel_addr_c  = core_addr[32'(arb_idx_c) * ADDR_W +: ADDR_W];
    sel_wdata_c = core_write_val[32'(arb_idx_c) * DATA_W +: DATA_W];
    sel_wr_c    = core_wren[arb_idx_c];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and control bookkeeping (grant latch, latency counter, pointer).
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_idx_d = gnt_idx_q;
    gnt_oh_d  = gnt_oh_q;
    is_wr_d   = is_wr_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (any_c) begin
          gnt_idx_d = arb_idx_c;
          gnt_oh_d  = arb_oh_c;
          is_wr_d   = sel_wr_c;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (is_wr_q) begin
          state_d = ST_DONE;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_DONE: begin
        ptr_d   = gnt_idx_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output values for the next cycle; everything idles at zero.
  always_comb begin
    core_enable_d   = '0;
    core_read_val_d = '0;
    mem_addr_d      = '0;
    mem_wdata_d     = '0;
    mem_rden_d      = 1'b0;
    mem_wren_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_c) begin
          mem_addr_d  = sel_addr_c;
          mem_wdata_d = sel_wdata_c;
          mem_wren_d  = sel_wr_c;
          mem_rden_d  = !sel_wr_c;
        end
      end
      ST_ISSUE: begin
        if (is_wr_q) core_enable_d = gnt_oh_q;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          core_enable_d   = gnt_oh_q;
          core_read_val_d = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers; reset discards any in-flight access.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q           <= PTR_RST;
      gnt_idx_q       <= '0;
      gnt_oh_q        <= '0;
      is_wr_q         <= 1'b0;
      cnt_q           <= '0;
      core_enable_q   <= '0;
      core_read_val_q <= '0;
      mem_addr_q      <= '0;
      mem_rden_q      <= 1'b0;
      mem_wren_q      <= 1'b0;
      mem_wdata_q     <= '0;
    end else begin
      ptr_q           <= ptr_d;
      gnt_idx_q       <= gnt_idx_d;
      gnt_oh_q        <= gnt_oh_d;
      is_wr_q         <= is_wr_d;
      cnt_q           <= cnt_d;
      core_enable_q   <= core_enable_d;
      core_read_val_q <= core_read_val_d;
      mem_addr_q      <= mem_addr_d;
      mem_rden_q      <= mem_rden_d;
      mem_wren_q      <= mem_wren_d;
      mem_wdata_q     <= mem_wdata_d;
    end
  end

  assign core_enable   = core_enable_q;
  assign core_read_val = core_read_val_q;
  assign mem_addr      = mem_addr_q;
  assign mem_rden      = mem_rden_q;
  assign mem_wren      = mem_wren_q;
  assign mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_core_memory_responder.sv
// Scoreboard bench: transaction-level reference model predicts strobes and completions.
module tb_core_memory_responder;

  localparam int unsigned NC = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned ML = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NC-1:0]        core_request, core_rden, core_wren, core_enable;
  logic [NC*AW-1:0]     core_addr;
  logic [NC*DW-1:0]     core_write_val;
  logic [DW-1:0]        core_read_val, mem_wdata, mem_rdata;
  logic [AW-1:0]        mem_addr;
  logic                 mem_rden, mem_wren;

  core_memory_responder #(
    .NUM_CORES   (NC),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .MEM_LATENCY (ML)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .core_request   (core_request),
    .core_addr      (core_addr),
    .core_rden      (core_rden),
    .core_wren      (core_wren),
    .core_write_val (core_write_val),
    .core_enable    (core_enable),
    .core_read_val  (core_read_val),
    .mem_addr       (mem_addr),
    .mem_rden       (mem_rden),
    .mem_wren       (mem_wren),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [AW-1:0] addr; logic wr; logic [DW-1:0] data; } strobe_t;
  typedef struct { int cyc; logic [NC-1:0] en; logic [DW-1:0] data; } done_t;

  strobe_t sq[$];
  done_t   dq[$];
  int checks = 0;
  int failures = 0;

  logic [DW-1:0] be_mem  [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endfunction

  function automatic void fail_evt(input string name, input int exp_cyc);
    checks++;
    failures++;
    $display("FAIL %s cyc=%0d expected_cyc=%0d", name, cyc, exp_cyc);
  endfunction

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [DW-1:0] be_read(input logic [AW-1:0] a);
    return be_mem.exists(a) ? be_mem[a] : init_val(a);
  endfunction

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // Backing memory: data appears exactly ML cycles after a read strobe, noise otherwise.
  int            ret_cyc = -1;
  logic [DW-1:0] ret_data;
  always @(negedge clk) begin
    if (mem_wren) be_mem[mem_addr] = mem_wdata;
    if (mem_rden) begin
      ret_cyc  = cyc + ML;
      ret_data = be_read(mem_addr);
    end
    mem_rdata = (cyc == ret_cyc) ? ret_data : DW'($urandom);
  end

  // Monitor: pops expected strobes/completions when the DUT presents them.
  always @(negedge clk) begin : mon
    strobe_t s;
    done_t   d;
    if (cyc >= 1) begin
      while (sq.size() > 0 && sq[0].cyc < cyc) begin
        fail_evt("missing_strobe", sq[0].cyc);
        void'(sq.pop_front());
      end
      while (dq.size() > 0 && dq[0].cyc < cyc) begin
        fail_evt("missing_enable", dq[0].cyc);
        void'(dq.pop_front());
      end
      if (mem_rden || mem_wren) begin
        chk("strobe_exclusive", 64'(mem_rden & mem_wren), 64'(0));
        if (sq.size() == 0 || sq[0].cyc != cyc) begin
          fail_evt("unexpected_strobe", -1);
        end else begin
          s = sq.pop_front();
          chk("strobe_is_write", 64'(mem_wren), 64'(s.wr));
          chk("mem_addr", 64'(mem_addr), 64'(s.addr));
          if (s.wr) chk("mem_wdata", 64'(mem_wdata), 64'(s.data));
        end
      end else begin
        chk("idle_mem_addr", 64'(mem_addr), 64'(0));
        chk("idle_mem_wdata", 64'(mem_wdata), 64'(0));
      end
      chk("enable_onehot0", 64'($onehot0(core_enable)), 64'(1));
      if (core_enable != '0) begin
        if (dq.size() == 0 || dq[0].cyc != cyc) begin
          fail_evt("unexpected_enable", -1);
        end else begin
          d = dq.pop_front();
          chk("core_enable", 64'(core_enable), 64'(d.en));
          chk("core_read_val", 64'(core_read_val), 64'(d.data));
        end
      end else begin
        chk("idle_read_val", 64'(core_read_val), 64'(0));
      end
    end
  end

  // Bench-side core state and reference model state.
  logic [NC-1:0] req_b, rd_b, wr_b;
  logic [AW-1:0] addr_a [NC];
  logic [DW-1:0] wd_a   [NC];
  bit            pend   [NC];
  bit            busy = 1'b0;
  bit            g_wr;
  int            g = 0, last_g = -1, ptr = NC - 1;
  int            done_cyc = 0, strobe_cyc = 0, idle_from = 0;
  int            ntx = 0, ndone = 0, phase = 0, arm_start = 0, post_target = 0, drain = 0;

  task automatic new_req(input int i, input int kind);
    pend[i]   = 1'b1;
    req_b[i]  = 1'b1;
    rd_b[i]   = (kind != 1);
    wr_b[i]   = (kind != 0);
    addr_a[i] = AW'($urandom_range(0, 7) * 4);
    wd_a[i]   = DW'($urandom);
  endtask

  task automatic drive();
    core_request = req_b;
    core_rden    = rd_b;
    core_wren    = wr_b;
    for (int i = 0; i < int'(NC); i++) begin
      core_addr[i*AW +: AW]      = addr_a[i];
      core_write_val[i*DW +: DW] = wd_a[i];
    end
  endtask

  // One cycle of stimulus plus reference-model prediction.
  task automatic step();
    int      c;
    int      r;
    int      cand;
    bit      found;
    bit      arm_hit;
    bit      any_pend;
    logic [DW-1:0] rdv;
    strobe_t s;
    done_t   d;
    c = cyc;
    if (busy && c == done_cyc) begin
      pend[g] = 1'b0; req_b[g] = 1'b0; rd_b[g] = 1'b0; wr_b[g] = 1'b0;
      busy = 1'b0; ndone++; last_g = g; idle_from = c + 1;
    end
    if (phase == 0 && ndone == 2) phase = 1;
    if (phase == 1 && ntx >= 10) phase = 2;
    if (phase == 2 && ntx >= 60) begin phase = 3; arm_start = c; end
    if (phase == 3 && c - arm_start > 400) begin
      fail_evt("reset_arm_timeout", arm_start + 400);
      phase = 4; post_target = ntx + 4;
    end
    if (phase == 4 && ntx >= post_target) phase = 5;
    any_pend = 1'b0;
    for (int i = 0; i < int'(NC); i++) any_pend |= pend[i];
    if (phase == 5 && !busy && !any_pend) begin
      drain++;
      if (drain > 10) phase = 6;
    end
    for (int i = 0; i < int'(NC); i++) begin
      if (!pend[i]) begin
        case (phase)
          1, 4: new_req(i, int'($urandom_range(0, 2)));
          3:    new_req(i, 0);
          2: begin
            r = int'($urandom_range(0, 9));
            if (r < 4)       begin req_b[i] = 1'b0; rd_b[i] = 1'b0; wr_b[i] = 1'b0; end
            else if (r < 6)  new_req(i, 0);
            else if (r == 6) new_req(i, 1);
            else if (r == 7) new_req(i, 2);
            else             begin req_b[i] = 1'b1; rd_b[i] = 1'b0; wr_b[i] = 1'b0; end
          end
          default: begin req_b[i] = 1'b0; rd_b[i] = 1'b0; wr_b[i] = 1'b0; end
        endcase
      end else if (busy && g == i && phase == 2) begin
        if ($urandom_range(0, 2) == 0) begin
          addr_a[i] = AW'($urandom);
          wd_a[i]   = DW'($urandom);
        end
        if ($urandom_range(0, 3) == 0) req_b[i] = 1'b0;
      end
    end
    arm_hit = (phase == 3) && busy && (g == 1) && !g_wr && (last_g == 0) && (c == strobe_cyc + 2);
    reset = !((c <= 3) || arm_hit);
    drive();
    if (!reset) begin
      while (dq.size() > 0 && dq[$].cyc > c) void'(dq.pop_back());
      while (sq.size() > 0 && sq[$].cyc > c) void'(sq.pop_back());
      busy = 1'b0; ptr = NC - 1; idle_from = c + 1;
      if (arm_hit) begin phase = 4; post_target = ntx + 4; end
    end else if (!busy && c >= idle_from) begin
      found = 1'b0;
      for (int k = 1; k <= int'(NC); k++) begin
        cand = (ptr + k) % int'(NC);
        if (!found && req_b[cand] && (rd_b[cand] || wr_b[cand])) begin
          found = 1'b1;
          g = cand;
        end
      end
      if (found) begin
        g_wr = wr_b[g];
        strobe_cyc = c + 1;
        if (g_wr) begin
          ref_mem[addr_a[g]] = wd_a[g];
          rdv = '0;
          done_cyc = c + 2;
        end else begin
          rdv = ref_read(addr_a[g]);
          done_cyc = c + 2 + int'(ML);
        end
        s.cyc = strobe_cyc; s.addr = addr_a[g]; s.wr = g_wr; s.data = wd_a[g];
        d.cyc = done_cyc;   d.en = NC'(1) << g;  d.data = rdv;
        sq.push_back(s);
        dq.push_back(d);
        busy = 1'b1; ptr = g; ntx++;
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    be_mem[32'h10]  = 32'hDEAD_BEEF;
    ref_mem[32'h10] = 32'hDEAD_BEEF;
    req_b = '1;
    rd_b  = 2'b10;
    wr_b  = 2'b01;
    pend[0] = 1'b1; addr_a[0] = 32'h4;  wd_a[0] = 32'h0000_CAFE;
    pend[1] = 1'b1; addr_a[1] = 32'h10; wd_a[1] = DW'($urandom);
    drive();
    while (phase != 6) begin
      @(negedge clk);
      if (cyc > 20000) begin
        fail_evt("run_timeout", 20000);
        break;
      end
      step();
    end
    @(negedge clk);
    chk("strobe_queue_drained", 64'(sq.size()), 64'(0));
    chk("enable_queue_drained", 64'(dq.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
